// File: rtl/sensor_frame_reader.sv
// Sweeps the sensor register file once per start request and streams the result as a
// framed packet (sync, sequence, payload, checksum) over a valid/ready byte interface.
module sensor_frame_reader #(
  parameter int unsigned FIRST_ADDR = 1,
  parameter int unsigned LAST_ADDR  = 23,
  parameter logic [7:0]  SYNC0      = 8'hAA,
  parameter logic [7:0]  SYNC1      = 8'h55
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       start_dropped,
  output logic [7:0] seq
);

  localparam logic [7:0] FirstAddr = FIRST_ADDR[7:0];
  localparam logic [7:0] LastAddr  = LAST_ADDR[7:0];

  typedef enum logic [2:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StHseq,
    StRaddr,
    StSend,
    StChk
  } state_e;

  state_e     state_q;
  logic [7:0] acc_q;
  logic       xfer;

  assign xfer = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      addr          <= '0;
      tx_data       <= '0;
      tx_valid      <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      start_dropped <= 1'b0;
      seq           <= '0;
      acc_q         <= '0;
    end else begin
      frame_done    <= 1'b0;
      // The frame_done cycle still counts as part of the finishing frame.
      start_dropped <= start && ((state_q != StIdle) || frame_done);
      unique case (state_q)
        StIdle: begin
          addr <= '0;
          busy <= 1'b0;
          if (start && !frame_done) begin
            tx_data  <= SYNC0;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            acc_q    <= '0;
            state_q  <= StHdr0;
          end
        end
        StHdr0: begin
          if (xfer) begin
            tx_data <= SYNC1;
            state_q <= StHdr1;
          end
        end
        StHdr1: begin
          if (xfer) begin
            tx_data <= seq;
            acc_q   <= seq;
            state_q <= StHseq;
          end
        end
        StHseq: begin
          if (xfer) begin
            tx_valid <= 1'b0;
            addr     <= FirstAddr;
            state_q  <= StRaddr;
          end
        end
        StRaddr: begin
          tx_data  <= data_in;
          acc_q    <= acc_q + data_in;
          tx_valid <= 1'b1;
          state_q  <= StSend;
        end
        StSend: begin
          if (xfer) begin
            if (addr == LastAddr) begin
              // acc already holds seq plus every payload byte
              tx_data <= 8'd0 - acc_q;
              addr    <= '0;
              state_q <= StChk;
            end else begin
              tx_valid <= 1'b0;
              addr     <= addr + 8'd1;
              state_q  <= StRaddr;
            end
          end
        end
        StChk: begin
          if (xfer) begin
            tx_valid   <= 1'b0;
            frame_done <= 1'b1;
            busy       <= 1'b0;
            seq        <= seq + 8'd1;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_frame_reader.sv
// Scoreboard bench for sensor_frame_reader: frames are predicted from the register
// contents when start is issued and checked byte by byte as the DUT hands them over.
module tb_sensor_frame_reader;

  typedef struct {
    logic [7:0] b;
    bit         last;
  } exp_t;
  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst, start, start2, tx_ready;
  logic [7:0] addr, data_in, tx_data, seq;
  logic       tx_valid, busy, frame_done, start_dropped;
  logic [7:0] addr2, data_in2, tx_data2, seq2;
  logic       tx_valid2, busy2, frame_done2, start_dropped2;

  logic [7:0] regs  [256];
  logic [7:0] regs2 [256];

  exp_t       exp_q[$];
  exp_t       exp2_q[$];
  int         checks = 0;
  int         passed = 0;
  int         dropped_cnt = 0;
  int         bytes2 = 0;
  int         ready_mode = 0;
  logic [7:0] model_seq = 8'd0;

  assign data_in  = regs[addr];
  assign data_in2 = regs2[addr2];

  always #5 clk = ~clk;

  sensor_frame_reader dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .data_in(data_in),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .frame_done(frame_done), .start_dropped(start_dropped), .seq(seq)
  );

  sensor_frame_reader #(.FIRST_ADDR(5), .LAST_ADDR(5)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .addr(addr2), .data_in(data_in2),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready), .busy(busy2),
    .frame_done(frame_done2), .start_dropped(start_dropped2), .seq(seq2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) $display("FAIL %s: got %0h, required %0h", name, act, req);
    else passed++;
  endtask

  // Reference frame: sync, seq, payload, two's-complement of the 8-bit running sum.
  function automatic bq_t make_frame(input logic [7:0] s, input int first, input int last,
                                     input bit second);
    bq_t  q;
    int   sum;
    q.push_back(8'hAA);
    q.push_back(8'h55);
    q.push_back(s);
    sum = int'(s);
    for (int a = first; a <= last; a++) begin
      q.push_back(second ? regs2[a] : regs[a]);
      sum += second ? int'(regs2[a]) : int'(regs[a]);
    end
    q.push_back(8'((256 - (sum % 256)) % 256));
    return q;
  endfunction

  task automatic push_frame();
    bq_t q;
    q = make_frame(model_seq, 1, 23, 1'b0);
    foreach (q[i]) exp_q.push_back('{b: q[i], last: (i == q.size() - 1)});
    model_seq++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    step();
    step();
    rst = 1'b0;
    model_seq = 8'd0;
    exp_q.delete();
    exp2_q.delete();
  endtask

  task automatic issue_start();
    int n = 0;
    while ((busy || frame_done) && n < 5000) begin
      step();
      n++;
    end
    if (n >= 5000) chk("start_wait_timeout", n, 0);
    start = 1'b1;
    push_frame();
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || frame_done || exp_q.size() != 0) && n < 5000) begin
      step();
      n++;
    end
    if (n >= 5000) chk("idle_wait_timeout", exp_q.size(), 0);
  endtask

  task automatic fill_regs(input bit rnd);
    for (int a = 0; a < 256; a++) regs[a] = rnd ? 8'($urandom_range(0, 255)) : 8'(a);
  endtask

  // Downstream readiness changes just after each edge.
  always @(posedge clk) begin
    #1;
    tx_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
  end

  // Monitor for the default instance: byte order, hold-while-stalled, frame_done timing.
  bit         hold_v = 1'b0;
  logic [7:0] hold_d;
  bit         done_pending = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
      done_pending = 1'b0;
    end else begin
      if (done_pending) begin
        chk("frame_done_pulse", frame_done, 1);
        chk("busy_after_done", busy, 0);
        done_pending = 1'b0;
      end else if (frame_done) begin
        chk("spurious_frame_done", frame_done, 0);
      end
      if (start_dropped) dropped_cnt++;
      if (hold_v) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_data", tx_data, hold_d);
      end
      hold_v = 1'b0;
      if (tx_valid) begin
        if (tx_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_byte_count", exp_q.size(), 1);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("tx_byte", tx_data, e.b);
            if (e.last) done_pending = 1'b1;
          end
        end else begin
          hold_v = 1'b1;
          hold_d = tx_data;
        end
      end
    end
  end

  bit done2_pending = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (done2_pending) begin
        chk("frame_done2_pulse", frame_done2, 1);
        done2_pending = 1'b0;
      end
      if (tx_valid2 && tx_ready) begin
        bytes2++;
        if (exp2_q.size() == 0) begin
          chk("unexpected_byte2_count", exp2_q.size(), 1);
        end else begin
          exp_t e;
          e = exp2_q.pop_front();
          chk("tx_byte2", tx_data2, e.b);
          if (e.last) done2_pending = 1'b1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1);
  end

  initial begin
    int n;
    bq_t q2;
    tx_ready = 1'b1;
    fill_regs(1'b0);
    for (int a = 0; a < 256; a++) regs2[a] = 8'h80;
    reset_dut();

    // Reset state and basic frame with latency
    chk("rst_addr", addr, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_start_dropped", start_dropped, 0);
    chk("rst_seq", seq, 0);
    start = 1'b1;
    push_frame();
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) begin
        start = 1'b0;
        chk("first_valid", tx_valid, 1);
        chk("first_busy", busy, 1);
      end
    end while (!frame_done && n < 200);
    chk("done_latency", n, 51);
    chk("seq_after_frame", seq, 1);
    wait_idle();

    // Backpressure: same data, then randomized register contents
    ready_mode = 1;
    issue_start();
    wait_idle();
    for (int f = 0; f < 3; f++) begin
      fill_regs(1'b1);
      issue_start();
      wait_idle();
    end
    chk("seq_after_bp", seq, model_seq);

    // Back-to-back frames through sequence wrap
    ready_mode = 0;
    fill_regs(1'b0);
    reset_dut();
    for (int f = 0; f < 257; f++) issue_start();
    wait_idle();
    chk("seq_wrap", seq, model_seq);

    // Dropped starts: mid-payload and on the frame_done cycle
    reset_dut();
    dropped_cnt = 0;
    issue_start();
    n = 0;
    while (addr != 8'd5 && n < 200) begin
      step();
      n++;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!frame_done && n < 200) begin
      step();
      n++;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    wait_idle();
    chk("dropped_count", dropped_cnt, 2);
    chk("busy_after_drop", busy, 0);
    chk("seq_after_drop", seq, model_seq);

    // Reset while sending the register at address 10
    reset_dut();
    issue_start();
    n = 0;
    while (!(addr == 8'd10 && tx_valid) && n < 200) begin
      step();
      n++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    model_seq = 8'd0;
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_seq", seq, model_seq);
    issue_start();
    wait_idle();
    chk("seq_after_rerun", seq, model_seq);

    // Single-register instance
    q2 = make_frame(8'd0, 5, 5, 1'b1);
    foreach (q2[i]) exp2_q.push_back('{b: q2[i], last: (i == q2.size() - 1)});
    bytes2 = 0;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    n = 0;
    while ((busy2 || exp2_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    step();
    chk("dut2_bytes", bytes2, 5);
    chk("dut2_queue_left", exp2_q.size(), 0);
    chk("dut2_seq", seq2, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
